wb_commit_monitor: RTL and testbench
====================================

Name: wb_commit_monitor

Overview:
- Sits directly downstream of the CPU write-back stage; consumes the per-cycle commit stream produced by `mips`.
- Filters register-file writes into a trace FIFO drained by a ready/valid consumer (bench logger or UART dumper).
- Counts retired instructions.
- Detects end of program (PC bound, self-loop or cycle timeout) and raises a sticky `done` once the trace has drained.

Parameters:
- FIFO_DEPTH, 8, trace FIFO entries; power of two, ≥2.
- END_PC, 32'h0000_7000, a commit with PC ≥ END_PC (unsigned) terminates the run.
- LOOP_LIMIT, 4, this many consecutive valid commits at the same PC terminate the run; ≥2.
- TIMEOUT_CYCLES, 100, cycles in RUN before forced termination; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_valid  in  1  an instruction retires this cycle.
- wb_pc  in  32  PC of the retiring instruction.
- wb_rf_we  in  1  retiring instruction writes the GPR file.
- wb_rf_addr  in  5  destination GPR.
- wb_rf_wdata  in  32  value written.
- trace_valid  out  1  FIFO head is valid.
- trace_ready  in  1  consumer accepts the head.
- trace_pc  out  32  head PC.
- trace_rf_addr  out  5  head register.
- trace_rf_wdata  out  32  head data.
- retire_count  out  32  number of retired instructions.
- done  out  1  run finished and trace fully drained; sticky.
- done_reason  out  2  0 none, 1 END_PC, 2 self-loop, 3 timeout.
- overflow  out  1  sticky: at least one trace record was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to RUN; FIFO is emptied.
  - All counters are cleared.
  - Outputs: trace_valid=0, trace_pc=0, trace_rf_addr=0, trace_rf_wdata=0, retire_count=0, done=0, done_reason=0, overflow=0.
  - Reset asserted mid-run or mid-drain aborts immediately; nothing is retained.
- FSM states:
  - RUN: accept commits.
  - DRAIN: ignore wb_* inputs, pop only.
  - DONE: terminal; done=1; leaves only via reset.
- A commit is a cycle in RUN with wb_valid=1.
  - If wb_pc ≥ END_PC: the commit is neither counted nor recorded; done_reason←1; next state DRAIN.
  - Otherwise retire_count increments by 1 (wraps at 2^32). If wb_rf_we=1 and wb_rf_addr≠0, push {wb_pc, wb_rf_addr, wb_rf_wdata}.
  - Writes to $0 are never recorded.
- Self-loop detection:
  - A loop counter tracks consecutive commits whose PC equals the previous commit's PC. It is set to 1 on a new PC. Cycles with wb_valid=0 do not reset it.
  - When it reaches LOOP_LIMIT: that commit is counted and recorded normally; done_reason←2; next state DRAIN.
  - Branch-to-self with a delay slot alternates PCs and is not detected; TIMEOUT covers that case.
- Timeout:
  - The cycle counter increments every cycle in RUN.
  - When it equals TIMEOUT_CYCLES−1 and no other termination fires that cycle: done_reason←3; next state DRAIN.
- Termination priority when conditions coincide in one cycle: END_PC > self-loop > timeout. done_reason is written once and then frozen.
- FIFO:
  - First-word fall-through; the head is on trace_* whenever trace_valid=1.
  - Pop occurs when trace_valid & trace_ready.
  - Push is accepted when occupancy < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - If FIFO is full with no pop, the push is dropped, overflow←1, and retire_count still increments.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - trace_* hold their values while trace_valid=1 and trace_ready=0.
  - When empty, trace_valid=0 and trace_* data is don't-care.
- DRAIN → DONE in the cycle after FIFO occupancy reaches 0. done=1 from DONE onward. If the FIFO is already empty on entry, DONE follows one cycle after DRAIN.
- retire_count is frozen outside RUN.

Test Plan:
- Reset, then commits pc=0x3000 (we=1, $8, 0x11) and pc=0x3004 (we=1, $0, 0x22) with trace_ready=1 → exactly one trace record {0x3000, 8, 0x11}; retire_count=2.
- trace_ready=0, 9 register-writing commits with FIFO_DEPTH=8 → occupancy 8, overflow=1, retire_count=9. Raise trace_ready → 8 records pop in push order, then trace_valid=0.
- Commit at pc=0x7000 → not counted or recorded; done_reason=1. With an empty FIFO, done=1 two cycles later. Later commits change nothing.
- Four consecutive commits at pc=0x3010 (wb_valid gaps in between) → done_reason=2 after the 4th; retire_count includes all 4.
- No commits for 100 cycles after reset release → done_reason=3, done=1. Assert reset during DRAIN with 3 queued records → all outputs return to 0 asynchronously; FIFO empty after release.
- Same cycle: pc=0x7000 commit while timeout fires → done_reason=1. Full FIFO with simultaneous pop and push → push accepted; overflow stays 0.

Source files
------------

// File: rtl/wb_commit_monitor.sv
// Purpose: filters write-back commits into a FWFT trace FIFO, counts retirements, detects end of run.
// Latency: a commit is visible on trace_* the cycle after it retires; done rises one cycle after the trace empties in DRAIN.
// Backpressure: trace_ready stalls the FIFO head; when full with no pop the record is dropped and overflow sticks.
//
// Ports: clk/reset (async, active-low); wb_* commit stream from the CPU;
//        trace_* ready/valid FIFO head; retire_count, done, done_reason, overflow status.
module wb_commit_monitor #(
   parameter int          FIFO_DEPTH     = 8,
   parameter logic [31:0] END_PC         = 32'h0000_7000,
   parameter int          LOOP_LIMIT     = 4,
   parameter int          TIMEOUT_CYCLES = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_valid,
   input  logic [31:0] wb_pc,
   input  logic        wb_rf_we,
   input  logic [4:0]  wb_rf_addr,
   input  logic [31:0] wb_rf_wdata,
   output logic        trace_valid,
   input  logic        trace_ready,
   output logic [31:0] trace_pc,
   output logic [4:0]  trace_rf_addr,
   output logic [31:0] trace_rf_wdata,
   output logic [31:0] retire_count,
   output logic        done,
   output logic [1:0]  done_reason,
   output logic        overflow
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_L  = (AW+1)'(FIFO_DEPTH);
   localparam logic [31:0] LOOP_L   = 32'(LOOP_LIMIT);
   localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

   state_t      state, state_nxt;
   logic [1:0]  reason_nxt;

   // FIFO storage; contents need no reset because trace_valid masks them.
   logic [31:0] mem_pc   [FIFO_DEPTH];
   logic [4:0]  mem_addr [FIFO_DEPTH];
   logic [31:0] mem_data [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;

   logic [31:0] last_pc;
   logic        prev_vld;
   logic [31:0] loop_cnt, loop_nxt;
   logic [31:0] cyc_cnt;

   logic commit, end_hit, counted, loop_hit, tmo_hit;
   logic push, pop, push_ok;

   assign commit  = (state == S_RUN) && wb_valid;
   assign end_hit = commit && (wb_pc >= END_PC);
   assign counted = commit && !end_hit;

   // Run length of identical PCs; idle cycles leave it untouched.
   assign loop_nxt = (prev_vld && (wb_pc == last_pc)) ? loop_cnt + 32'd1 : 32'd1;
   assign loop_hit = counted && (loop_nxt == LOOP_L);
   assign tmo_hit  = TMO_EN && (state == S_RUN) && (cyc_cnt == TMO_LAST) && !end_hit && !loop_hit;

   assign trace_valid = (count != '0);
   assign pop         = trace_valid && trace_ready;
   assign push        = counted && wb_rf_we && (wb_rf_addr != 5'd0);
   // A pop frees a slot in the same cycle, so a full FIFO still accepts.
   assign push_ok     = push && ((count < DEPTH_L) || pop);

   assign trace_pc       = trace_valid ? mem_pc[rd_ptr]   : '0;
   assign trace_rf_addr  = trace_valid ? mem_addr[rd_ptr] : '0;
   assign trace_rf_wdata = trace_valid ? mem_data[rd_ptr] : '0;
   assign done           = (state == S_DONE);

   always_comb begin
      state_nxt  = state;
      reason_nxt = done_reason;
      case (state)
         S_RUN: begin
            if (end_hit) begin
               state_nxt  = S_DRAIN;
               reason_nxt = 2'd1;
            end else if (loop_hit) begin
               state_nxt  = S_DRAIN;
               reason_nxt = 2'd2;
            end else if (tmo_hit) begin
               state_nxt  = S_DRAIN;
               reason_nxt = 2'd3;
            end
         end
         // Occupancy seen here is pre-pop, so DONE lands the cycle after it hits zero.
         S_DRAIN: if (count == '0) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_DONE;
         default: state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_RUN;
         done_reason  <= 2'd0;
         retire_count <= '0;
         overflow     <= 1'b0;
         last_pc      <= '0;
         prev_vld     <= 1'b0;
         loop_cnt     <= '0;
         cyc_cnt      <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
      end else begin
         state       <= state_nxt;
         done_reason <= reason_nxt;
         if (state == S_RUN) cyc_cnt <= cyc_cnt + 32'd1;
         if (counted) begin
            retire_count <= retire_count + 32'd1;
            last_pc      <= wb_pc;
            prev_vld     <= 1'b1;
            loop_cnt     <= loop_nxt;
         end
         if (push && !push_ok) overflow <= 1'b1;
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_pc[wr_ptr]   <= wb_pc;
         mem_addr[wr_ptr] <= wb_rf_addr;
         mem_data[wr_ptr] <= wb_rf_wdata;
      end
   end

endmodule

// File: tb/tb_wb_commit_monitor.sv
// Purpose: drives wb_commit_monitor with directed and random commit streams against a queue-based model.
// Latency: outputs compared once per cycle, 1 ns after inputs change on the falling edge.
// Backpressure: trace_ready driven directed or with a random per-episode probability.
module tb_wb_commit_monitor;

   localparam int          DEPTH = 8;
   localparam logic [31:0] ENDPC = 32'h0000_7000;
   localparam int          LIMIT = 4;
   localparam int          TMO   = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wb_valid = 1'b0;
   logic [31:0] wb_pc = '0;
   logic        wb_rf_we = 1'b0;
   logic [4:0]  wb_rf_addr = '0;
   logic [31:0] wb_rf_wdata = '0;
   logic        trace_ready = 1'b0;
   logic        trace_valid;
   logic [31:0] trace_pc;
   logic [4:0]  trace_rf_addr;
   logic [31:0] trace_rf_wdata;
   logic [31:0] retire_count;
   logic        done;
   logic [1:0]  done_reason;
   logic        overflow;

   wb_commit_monitor #(
      .FIFO_DEPTH(DEPTH), .END_PC(ENDPC), .LOOP_LIMIT(LIMIT), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we),
      .wb_rf_addr(wb_rf_addr), .wb_rf_wdata(wb_rf_wdata),
      .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_pc(trace_pc), .trace_rf_addr(trace_rf_addr), .trace_rf_wdata(trace_rf_wdata),
      .retire_count(retire_count), .done(done), .done_reason(done_reason), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: run phase 0=RUN 1=DRAIN 2=DONE, trace as a queue of records.
   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  a;
      logic [31:0] d;
   } rec_t;

   rec_t        q[$];
   int          phase;
   logic [31:0] m_rc;
   int          m_reason;
   bit          m_ovf;
   logic [31:0] m_last;
   bit          m_have;
   int          m_run;
   int          m_cycles;

   task automatic model_reset();
      q.delete();
      phase = 0; m_rc = '0; m_reason = 0; m_ovf = 0;
      m_last = '0; m_have = 0; m_run = 0; m_cycles = 0;
   endtask

   task automatic model_step();
      bit   pop;
      bit   push;
      bit   stop;
      int   nxt;
      rec_t r;
      pop = (q.size() > 0) && trace_ready;
      push = 0; stop = 0; nxt = phase;
      if (phase == 0) begin
         if (wb_valid) begin
            if (wb_pc >= ENDPC) begin
               m_reason = 1; stop = 1;
            end else begin
               m_rc = m_rc + 32'd1;
               m_run = (m_have && wb_pc == m_last) ? m_run + 1 : 1;
               m_last = wb_pc; m_have = 1;
               if (wb_rf_we && wb_rf_addr != 5'd0) begin
                  if (q.size() < DEPTH || pop) push = 1;
                  else m_ovf = 1;
               end
               if (m_run == LIMIT) begin
                  m_reason = 2; stop = 1;
               end
            end
         end
         if (!stop && m_cycles == TMO - 1) begin
            m_reason = 3; stop = 1;
         end
         m_cycles++;
         if (stop) nxt = 1;
      end else if (phase == 1) begin
         if (q.size() == 0) nxt = 2;
      end
      if (pop) void'(q.pop_front());
      if (push) begin
         r.pc = wb_pc; r.a = wb_rf_addr; r.d = wb_rf_wdata;
         q.push_back(r);
      end
      phase = nxt;
   endtask

   task automatic check_outputs();
      chk("trace_valid", trace_valid, q.size() > 0);
      if (q.size() > 0) begin
         chk("trace_pc", trace_pc, q[0].pc);
         chk("trace_rf_addr", trace_rf_addr, q[0].a);
         chk("trace_rf_wdata", trace_rf_wdata, q[0].d);
      end
      chk("retire_count", retire_count, m_rc);
      chk("done", done, phase == 2);
      chk("done_reason", done_reason, m_reason);
      chk("overflow", overflow, m_ovf);
   endtask

   // One clock: drive after the falling edge, compare, let the rising edge commit.
   task automatic step(input bit v, input logic [31:0] pc, input bit we,
                       input logic [4:0] a, input logic [31:0] d, input bit rdy);
      wb_valid = v; wb_pc = pc; wb_rf_we = we; wb_rf_addr = a; wb_rf_wdata = d;
      trace_ready = rdy;
      #1 check_outputs();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle(input bit rdy);
      step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, rdy);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      wb_valid = 1'b0; wb_rf_we = 1'b0; trace_ready = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_outputs();
      chk("rst_trace_pc", trace_pc, 32'h0);
      chk("rst_trace_addr", trace_rf_addr, 32'h0);
      chk("rst_trace_data", trace_rf_wdata, 32'h0);
      reset = 1'b1;
   endtask

   initial begin
      int rdy_pct, val_pct, npc;
      bit allow_end;
      logic [31:0] pc;

      // Basic filtering: $0 write is dropped.
      do_reset();
      step(1, 32'h3000, 1, 5'd8, 32'h11, 1);
      step(1, 32'h3004, 1, 5'd0, 32'h22, 1);
      idle(1); idle(1);
      chk("basic_rc", retire_count, 32'd2);

      // Overflow with consumer stalled, then in-order drain.
      do_reset();
      for (int i = 0; i < 9; i++)
         step(1, 32'h3100 + 32'(4*i), 1, 5'(i+1), 32'hA0 + 32'(i), 0);
      idle(0);
      chk("ovf_flag", overflow, 32'd1);
      chk("ovf_rc", retire_count, 32'd9);
      for (int i = 0; i < 10; i++) idle(1);

      // END_PC termination, later commits ignored.
      do_reset();
      step(1, 32'h3000, 0, 5'd0, 32'h0, 1);
      step(1, ENDPC, 1, 5'd5, 32'h55, 1);
      for (int i = 0; i < 4; i++) step(1, 32'h3000 + 32'(8*i), 1, 5'd6, 32'h66, 1);
      chk("end_done", done, 32'd1);
      chk("end_reason", done_reason, 32'd1);
      chk("end_rc", retire_count, 32'd1);

      // Self-loop with idle gaps.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1, 32'h3010, 1, 5'd3, 32'(i), 1);
         idle(1);
      end
      for (int i = 0; i < 4; i++) idle(1);
      chk("loop_reason", done_reason, 32'd2);
      chk("loop_rc", retire_count, 32'd4);

      // Timeout with no commits.
      do_reset();
      for (int i = 0; i < TMO + 3; i++) idle(1);
      chk("tmo_reason", done_reason, 32'd3);
      chk("tmo_done", done, 32'd1);

      // Asynchronous reset while draining three records.
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 32'h3200 + 32'(4*i), 1, 5'd9, 32'(i), 0);
      step(1, ENDPC, 0, 5'd0, 32'h0, 0);
      idle(0);
      #2 reset = 1'b0;
      #1;
      chk("arst_valid", trace_valid, 32'd0);
      chk("arst_pc", trace_pc, 32'd0);
      chk("arst_addr", trace_rf_addr, 32'd0);
      chk("arst_data", trace_rf_wdata, 32'd0);
      chk("arst_rc", retire_count, 32'd0);
      chk("arst_done", done, 32'd0);
      chk("arst_reason", done_reason, 32'd0);
      chk("arst_ovf", overflow, 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      idle(1); idle(1);

      // END_PC commit on the timeout cycle wins.
      do_reset();
      for (int i = 0; i < TMO - 1; i++) idle(1);
      step(1, ENDPC, 0, 5'd0, 32'h0, 1);
      idle(1); idle(1);
      chk("prio_reason", done_reason, 32'd1);

      // Full FIFO accepts a push when a pop happens in the same cycle.
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1, 32'h3300 + 32'(4*i), 1, 5'd4, 32'(i), 0);
      step(1, 32'h3400, 1, 5'd7, 32'h77, 1);
      chk("full_pp_ovf", overflow, 32'd0);
      for (int i = 0; i < DEPTH + 2; i++) idle(1);

      // Random episodes.
      for (int ep = 0; ep < 30; ep++) begin
         do_reset();
         rdy_pct = $urandom_range(10, 95);
         val_pct = $urandom_range(20, 90);
         npc = $urandom_range(1, 4);
         allow_end = (ep % 3) != 0;
         for (int n = 0; n < 130; n++) begin
            if (allow_end && $urandom_range(0, 39) == 0)
               pc = ENDPC + 32'(4 * $urandom_range(0, 3));
            else
               pc = 32'h3000 + 32'(4 * $urandom_range(0, npc - 1));
            step($urandom_range(0, 99) < val_pct, pc, $urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 99) < rdy_pct);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
